chip8_step_ctrl: RTL
====================

Name: chip8_step_ctrl

Overview:
- Conditions the raw board buttons and turns them into CPU step commands for the CHIP-8 core: single step or free-running at a divided rate.
- Sits between the top-level button pins and the CPU execute-enable input.
- Receiver end of the button stimulus: the bench drives btn[1] pulses, and this block converts them into step_out handshakes.

Parameters:
- NUM_BTNS, 4, number of button inputs conditioned.
- DEBOUNCE_CYCLES, 1000000, stable cycles needed before a level change is accepted. 0 = bypass (synchroniser only); sims use 0.
- RUN_DIV, 16, clock cycles between auto-step requests in run mode. Must be ≥2.
- CNT_W, 16, width of step_count_out.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_n_in  input  1  asynchronous active-low reset
- btn_in  input  NUM_BTNS  raw buttons, asynchronous. [1]=step, [2]=run/stop toggle, [0],[3] conditioned only.
- cpu_ready_in  input  1  CPU idle and able to accept a step
- step_out  output  1  one-cycle step command to the CPU
- mode_out  output  1  0 = single-step, 1 = run
- pending_out  output  1  a step request is latched but not yet issued
- btn_level_out  output  NUM_BTNS  debounced button levels
- btn_rise_out  output  NUM_BTNS  one-cycle pulse per debounced rising edge
- step_count_out  output  CNT_W  total steps issued

Behaviour:
- Reset (async assert, sync release via the flops) sets every output and all internal state to 0. Mode comes up as single-step.
- Each button passes through a 2-flop synchroniser, then the debouncer.
- Debouncer:
  - A per-button counter loads 0 whenever the synced input equals the current level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the level flips and the counter clears.
  - Bypass latency (DEBOUNCE_CYCLES=0): btn_in to btn_level_out = 3 clocks.
- btn_rise_out[i] = level & ~level_prev, registered, high exactly one cycle. A 1-cycle raw pulse yields exactly one rise in bypass mode.
- Mode toggle:
  - btn_rise_out[2] flips mode_out on the next cycle.
  - Toggling clears the run divider and drops any pending request.
- Request source:
  - Step mode: btn_rise_out[1].
  - Run mode: the divider counts 0..RUN_DIV-1 and requests on terminal count. btn_rise_out[1] is ignored.
- FSM states: S_IDLE, S_PEND, S_COOL.
  - S_IDLE, request arrives, cpu_ready_in=1: step_out=1 that cycle's next edge (registered). Go to S_COOL.
  - S_IDLE, request arrives, cpu_ready_in=0: go to S_PEND, pending_out=1.
  - S_PEND: issue step_out when cpu_ready_in=1, then go to S_COOL. Further requests while pending are dropped (one-deep).
  - S_COOL: ignore cpu_ready_in for one cycle (the CPU deasserts ready with its registered latency). Requests arriving in S_COOL are latched into S_PEND.
  - Return from S_COOL to S_IDLE, or to S_PEND if a request was latched.
- Request and toggle in the same cycle: the toggle wins and the request is dropped.
- step_out is never high on two consecutive cycles.
- step_count_out increments on each step_out and wraps from all-ones to 0.
- Reset asserted mid-operation returns immediately to S_IDLE with step_out=0. A latched pending step is lost.

Decomposition:
- chip8_pkg holds:
  - the step FSM state enum (step_state_t);
  - button index constants BTN_RST=0, BTN_STEP=1, BTN_RUN=2;
  - MODE_STEP / MODE_RUN localparams.
- Sub-module btn_debounce: one instance per button via generate. Contains the synchroniser, counter, level and rise pulse; parameter DEBOUNCE_CYCLES.

Test Plan:
- DEBOUNCE_CYCLES=0, cpu_ready_in=1, 1-cycle pulse on btn_in[1] → one step_out pulse 4 clocks later, step_count_out=1. Seven pulses 500 cycles apart → step_count_out=7.
- cpu_ready_in=0, pulse btn_in[1] twice → pending_out=1 and no step_out. Raise ready → exactly one step_out, pending_out=0, count=1.
- Pulse btn_in[2], RUN_DIV=16, ready=1 → mode_out=1 and step_out every 16 cycles. Pulses on btn_in[1] change nothing. Pulse btn_in[2] again → mode_out=0, steps stop, pending cleared.
- DEBOUNCE_CYCLES=4: 3-cycle glitch on btn_in[1] → no rise, no step. 10-cycle press → exactly one rise and one step.
- Preload step_count_out to 0xFFFF via 65535 run-mode steps, then one more step → wraps to 0x0000.
- Assert rst_n_in low while in S_PEND → all outputs 0 asynchronously. After release, raising ready issues no step.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 step controller.
package chip8_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_COOL = 2'd2
  } step_state_t;

  localparam int BTN_RST  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_RUN  = 2;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level
// and a one-cycle rising-edge pulse. DEBOUNCE_CYCLES=0 leaves only the
// synchroniser plus the level register.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_in,
  output logic level_out,
  output logic rise_out
);

  logic sync1_q, sync2_q;
  logic level_q, level_d;
  logic rise_q, rise_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign level_d = sync2_q;
    end else begin : g_count
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [CW-1:0] cnt_q, cnt_d;

      // Count consecutive cycles the synced input disagrees with the level.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Stability counter register.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cnt_q <= '0;
        else           cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Rise is computed from the incoming level so it lands with the level change.
  always_comb begin
    rise_d = level_d & ~level_q;
  end

  // Level and edge-pulse registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;

endmodule

// File: rtl/chip8_step_ctrl.sv
// Turns conditioned buttons into one-cycle CPU step commands, either on
// each step-button press or free-running every RUN_DIV cycles.
module chip8_step_ctrl
  import chip8_pkg::*;
#(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 16,
  parameter int CNT_W           = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [NUM_BTNS-1:0] btn_in,
  input  logic                cpu_ready_in,
  output logic                step_out,
  output logic                mode_out,
  output logic                pending_out,
  output logic [NUM_BTNS-1:0] btn_level_out,
  output logic [NUM_BTNS-1:0] btn_rise_out,
  output logic [CNT_W-1:0]    step_count_out
);

  localparam int DIV_W = $clog2(RUN_DIV);

  step_state_t      state_q, state_d;
  logic             mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic toggle, div_tc, step_req;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .btn_in   (btn_in[i]),
      .level_out(btn_level_out[i]),
      .rise_out (btn_rise_out[i])
    );
  end

  assign toggle   = btn_rise_out[BTN_RUN];
  assign div_tc   = (mode_q == MODE_RUN) && (div_q == DIV_W'(RUN_DIV - 1));
  assign step_req = (mode_q == MODE_RUN) ? div_tc : btn_rise_out[BTN_STEP];

  // Mode flip and run-rate divider; a toggle restarts the divider from zero.
  always_comb begin
    mode_d = mode_q;
    div_d  = div_q;
    if (toggle) begin
      mode_d = ~mode_q;
      div_d  = '0;
    end else if (mode_q == MODE_RUN) begin
      div_d = div_tc ? '0 : div_q + DIV_W'(1);
    end
  end

  // Step handshake FSM; a toggle overrides and discards any request.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    if (toggle) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_req) begin
            if (cpu_ready_in) begin
              step_d  = 1'b1;
              state_d = S_COOL;
            end else begin
              state_d = S_PEND;
            end
          end
        end
        S_PEND: begin
          if (cpu_ready_in) begin
            step_d  = 1'b1;
            state_d = S_COOL;
          end
        end
        S_COOL: begin
          // Ready is still stale from before the step; only latch requests.
          state_d = step_req ? S_PEND : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Step counter advances together with the registered step pulse.
  always_comb begin
    cnt_d = step_d ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_STEP;
      div_q   <= '0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step_out       = step_q;
  assign mode_out       = mode_q;
  assign pending_out    = (state_q == S_PEND);
  assign step_count_out = cnt_q;

endmodule
